fsm_rr_arbiter: RTL and testbench

FSM_RR_ARBITER -- requirements
Module: fsm_rr_arbiter

---
 rtl/fsm_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fsm_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// fsm_rr_arbiter: round-robin arbiter handing a shared datapath to one of N requesters.
// A grant runs IDLE -> GRANT -> COOL -> IDLE. Every output comes straight from a flop.
// Optional build macro FSM_ARB_TIMEOUT_EN caps a grant at MAX_HOLD cycles and pulses
// timeout for the COOL cycle that follows a forced release.
module fsm_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IdW       = $clog2(N);
    localparam logic [7:0]  HoldLimit = 8'(MAX_HOLD - 1);
    localparam logic [7:0]  HoldMax   = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StCool
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [IdW-1:0]   last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             any_req;
    logic             found;
    logic [IdW-1:0]   cand;
    logic [IdW-1:0]   winner;
    logic             release_c;
    logic             at_limit;
    logic [7:0]       hold_inc;

    assign any_req = |req;

    // Round-robin search: first requester after last_q, wrapping modulo N.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdW'((32'(last_q) + k) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Only the current owner's done/req can end a grant; other bits are ignored.
    assign release_c = done[id_q] | ~req[id_q];

`ifdef FSM_ARB_TIMEOUT_EN
    assign at_limit = (hold_q == HoldLimit);
`else
    assign at_limit = 1'b0;
`endif

    // Hold counter never wraps; it parks at its maximum.
    assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + 8'd1;

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            id_q      <= '0;
            last_q    <= IdW'(N - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // A normal release takes precedence over the hold limit.
                if (release_c || at_limit) begin
                    state_d = StCool;
                end
            end
            StCool: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        grant_d   = grant_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        busy_d    = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (state_d == StGrant) begin
                    grant_d = N'(1) << winner;
                    id_d    = winner;
                    last_d  = winner;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                hold_d = hold_inc;
                if (state_d == StCool) begin
                    grant_d   = '0;
                    timeout_d = at_limit & ~release_c;
                end
            end
            StCool: begin
                grant_d = '0;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Testbench for fsm_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_fsm_rr_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef FSM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int n_vec = 0;
    int n_bad = 0;

    fsm_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: who owns the datapath, for how long, and whether a cool-down
    // cycle is pending. Updated from the same inputs the DUT samples.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_id    = 0;
    int m_held  = 0;
    bit m_cool  = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin : model
        int o, l, id, h, c;
        bit cl, t, rel, lim;
        o = m_owner; l = m_last; id = m_id; h = m_held; cl = m_cool; t = 1'b0;
        if (!reset) begin
            o = -1; l = N - 1; id = 0; h = 0; cl = 1'b0;
        end else if (o >= 0) begin
            h   = h + 1;
            rel = done[o] || !req[o];
            lim = TO_EN && (h >= MAX_HOLD);
            if (rel || lim) begin
                t  = lim && !rel;
                o  = -1;
                cl = 1'b1;
            end
        end else if (cl) begin
            cl = 1'b0;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                c = (l + k) % N;
                if (req[c]) begin
                    o = c; l = c; id = c; h = 0;
                    break;
                end
            end
        end
        m_owner <= o; m_last <= l; m_id <= id; m_held <= h; m_cool <= cl; m_to <= t;
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        chk("grant",    32'(grant),    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("grant_id", 32'(grant_id), 32'(m_id));
        chk("busy",     32'(busy),     32'((m_owner >= 0) || m_cool));
        chk("timeout",  32'(timeout),  32'(m_to));
        chk("onehot",   32'($onehot0(grant)), 32'd1);
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        @(negedge clk);
    endtask

    int cnt;
    logic [N-1:0] r_rand;
    logic [N-1:0] d_rand;

    initial begin
        reset = 1'b0;
        req   = '0;
        done  = '0;
        @(negedge clk);
        chk("rst_grant",   32'(grant),    32'd0);
        chk("rst_id",      32'(grant_id), 32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_timeout", 32'(timeout),  32'd0);
        reset = 1'b1;

        // First arbitration: requester 0 has priority, but only 1 and 3 ask.
        step(4'b1010, 4'b0000);
        chk("first_grant", 32'(grant),    32'h2);
        chk("first_id",    32'(grant_id), 32'd1);
        chk("first_busy",  32'(busy),     32'd1);
        step(4'b1010, 4'b0010);
        chk("cool_grant",  32'(grant), 32'd0);
        chk("cool_busy",   32'(busy),  32'd1);
        step(4'b1010, 4'b0000);
        chk("idle_grant",  32'(grant), 32'd0);
        chk("idle_busy",   32'(busy),  32'd0);
        step(4'b1010, 4'b0000);
        chk("rr_grant",    32'(grant),    32'h8);
        chk("rr_id",       32'(grant_id), 32'd3);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        chk("idle_hold",   32'(grant), 32'd0);

        // All requesting: strict rotation 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0000);
            chk("rot_grant", 32'(grant),    32'd1 << (k % 4));
            chk("rot_id",    32'(grant_id), 32'(k % 4));
            step(4'b1111, 4'((32'd1 << (k % 4))));
            step(4'b1111, 4'b0000);
        end

        // Reset mid-grant drops ownership with no cool-down or timeout.
        step(4'b0100, 4'b0000);
        chk("pre_rst_grant", 32'(grant), 32'h4);
        reset = 1'b0;
        step(4'b0100, 4'b0000);
        chk("mid_rst_grant",   32'(grant),   32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b1;
        step(4'b0001, 4'b0000);
        chk("post_rst_grant", 32'(grant), 32'h1);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Long hold by a single owner.
        step(4'b0001, 4'b0000);
`ifdef FSM_ARB_TIMEOUT_EN
        cnt = 1;
        while (grant != '0 && cnt < 20) begin
            step(4'b0001, 4'b0000);
            if (grant != '0) cnt++;
        end
        chk("hold_cycles", 32'(cnt),     32'(MAX_HOLD));
        chk("to_pulse",    32'(timeout), 32'd1);
        chk("to_busy",     32'(busy),    32'd1);
        step(4'b0000, 4'b0000);
        chk("to_clear",    32'(timeout), 32'd0);
        step(4'b0001, 4'b0000);
        repeat (MAX_HOLD - 1) step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0001);
        chk("limit_rel_grant",   32'(grant),   32'd0);
        chk("limit_rel_timeout", 32'(timeout), 32'd0);
`else
        repeat (300) step(4'b0001, 4'b0000);
        chk("long_grant",   32'(grant),   32'h1);
        chk("long_timeout", 32'(timeout), 32'd0);
`endif
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Randomized traffic, with occasional resets and long stubborn holds.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) != 0);
            r_rand = 4'($urandom | $urandom);
            d_rand = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ((i / 200) % 3 == 2) begin
                d_rand = 4'b0000;
                r_rand = 4'b1111;
            end
            step(r_rand, d_rand);
        end
        reset = 1'b1;
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
